pll_lock_sequencer: RTL
=======================

PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 Parameter RST_CYCLES, default 16: cycles PLL_RESETB is held low per attempt; legal range 1 to 65535.
REQ-002 Parameter LOCK_TIMEOUT, default 12000: cycles allowed for lock per attempt (1 ms at 12 MHz); legal range 1 to 65535.
REQ-003 Parameter SETTLE_CYCLES, default 1200: consecutive synchronized-lock cycles required before release; legal range 1 to 65535.
REQ-004 Parameter MAX_RETRIES, default 3: failed attempts tolerated before FAIL; legal range 1 to 15.
REQ-005 CLK  input  1: reference clock (the PLL input clock, not the PLL output).
REQ-006 RESET  input  1: synchronous, active-high reset.
REQ-007 PLL_LOCK  input  1: raw PLL LOCK, asynchronous to CLK.
REQ-008 RESTART  input  1: single-cycle request to re-run the sequence.
REQ-009 PLL_RESETB  output  1: active-low PLL reset.
REQ-010 PLL_BYPASS  output  1: PLL bypass select.
REQ-011 SYS_RESET  output  1: active-high reset for the PLL-clocked domain.
REQ-012 PLL_READY  output  1: high only in RUN.
REQ-013 PLL_FAIL  output  1: high only in FAIL.
REQ-014 STATE  output  3: encoding RST=0, WAIT=1, SETTLE=2, RUN=3, FAIL=4.
REQ-015 RETRY_CNT  output  4: number of failed attempts in the current sequence.
REQ-016 LOSS_CNT  output  8: lock-loss events in RUN since reset; saturates at 255.

Function
REQ-017 PLL_LOCK SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value (lock_s), 2 cycles of latency.
REQ-018 One shared 16-bit down-counter SHALL time RST, WAIT and SETTLE; it is reloaded on every state entry.
REQ-019 RST: PLL_RESETB=0 for exactly RST_CYCLES cycles, then go to WAIT.
REQ-020 WAIT: PLL_RESETB=1; lock_s=1 -> SETTLE; after LOCK_TIMEOUT cycles with lock_s=0 -> RETRY_CNT+1, then RST (or FAIL if RETRY_CNT reaches MAX_RETRIES).
REQ-021 SETTLE: lock_s=0 on any cycle -> back to WAIT with a fresh timeout, RETRY_CNT unchanged; SETTLE_CYCLES consecutive cycles with lock_s=1 -> RUN.
REQ-022 RUN: SYS_RESET=0 and PLL_READY=1; lock_s falling to 0 -> LOSS_CNT+1 (saturating), RETRY_CNT cleared, go to RST; SYS_RESET reasserts in the same cycle STATE leaves RUN.
REQ-023 SYS_RESET SHALL be 1 in every state except RUN, and in FAIL with bypass active per REQ-030.
REQ-024 FAIL is terminal; only RESTART or RESET leaves it.
REQ-025 RESTART in any state SHALL clear RETRY_CNT and go to RST on the next cycle; RESTART has priority over every other transition in the same cycle.
REQ-026 A lock loss in RUN in the same cycle as RESTART SHALL still increment LOSS_CNT.
REQ-027 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-028 RESET SHALL force STATE=RST, counter reloaded to RST_CYCLES, synchronizer=0, RETRY_CNT=0, LOSS_CNT=0, PLL_RESETB=0, PLL_BYPASS=0, SYS_RESET=1, PLL_READY=0, PLL_FAIL=0.
REQ-029 RESET asserted mid-sequence, including in RUN, SHALL abort immediately; the sequence restarts from RST after RESET deasserts.

Configuration
REQ-030 With macro PLL_SEQ_BYPASS_FALLBACK_EN defined, FAIL SHALL drive PLL_BYPASS=1, PLL_RESETB=1 and SYS_RESET=0, so the system runs at the reference clock; PLL_BYPASS returns to 0 on RESTART.
REQ-031 Without PLL_SEQ_BYPASS_FALLBACK_EN, PLL_BYPASS SHALL be constant 0, FAIL SHALL hold PLL_RESETB=0 and SYS_RESET=1, and no bypass logic is synthesized.

Verification
Benches use RST_CYCLES=4, LOCK_TIMEOUT=20, SETTLE_CYCLES=8, MAX_RETRIES=2.
REQ-032 Nominal lock: release RESET, raise PLL_LOCK 5 cycles after PLL_RESETB rises -> SETTLE entered 2 cycles later; RUN (SYS_RESET=0) 8 cycles after SETTLE entry.
REQ-033 Lock glitch: drop PLL_LOCK for 1 cycle at SETTLE cycle 5 -> return to WAIT; RETRY_CNT stays 0; RUN reached only after 8 clean cycles.
REQ-034 Timeout to FAIL: PLL_LOCK held 0 -> two 20-cycle WAIT windows, RETRY_CNT 1 then 2, STATE=4, PLL_FAIL=1; PLL_BYPASS=1 and SYS_RESET=0 only when the macro is defined.
REQ-035 Loss in RUN: drop PLL_LOCK -> LOSS_CNT=1, SYS_RESET=1, STATE=0; repeat 300 times -> LOSS_CNT=255.
REQ-036 Collisions: assert RESTART in FAIL -> STATE=0, RETRY_CNT=0, PLL_BYPASS=0 next cycle; assert RESTART in the same cycle as a RUN lock loss -> STATE=0 and LOSS_CNT incremented.

Source files
------------

// File: rtl/pll_lock_sequencer_if.sv
// Control/status bundle between the PLL lock sequencer (master) and the PLL/system side (slave).
interface pll_lock_sequencer_if;
  logic       PLL_LOCK;
  logic       RESTART;
  logic       PLL_RESETB;
  logic       PLL_BYPASS;
  logic       SYS_RESET;
  logic       PLL_READY;
  logic       PLL_FAIL;
  logic [2:0] STATE;
  logic [3:0] RETRY_CNT;
  logic [7:0] LOSS_CNT;

  modport master (
    input  PLL_LOCK, RESTART,
    output PLL_RESETB, PLL_BYPASS, SYS_RESET, PLL_READY, PLL_FAIL,
           STATE, RETRY_CNT, LOSS_CNT
  );

  modport slave (
    output PLL_LOCK, RESTART,
    input  PLL_RESETB, PLL_BYPASS, SYS_RESET, PLL_READY, PLL_FAIL,
           STATE, RETRY_CNT, LOSS_CNT
  );
endinterface

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: RST -> WAIT -> SETTLE -> RUN with timeout retries and a terminal FAIL.
// Optional bypass fallback in FAIL is enabled by defining PLL_SEQ_BYPASS_FALLBACK_EN.
module pll_lock_sequencer #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 12000,
  parameter int unsigned SETTLE_CYCLES = 1200,
  parameter int unsigned MAX_RETRIES   = 3
) (
  input  logic                 CLK,
  input  logic                 RESET,
  pll_lock_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_WAIT   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_FAIL   = 3'd4
  } state_e;

  localparam logic [15:0] RST_LOAD    = 16'(RST_CYCLES);
  localparam logic [15:0] WAIT_LOAD   = 16'(LOCK_TIMEOUT);
  localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYCLES);
  localparam logic [3:0]  RETRY_MAX   = 4'(MAX_RETRIES);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        sync1_q, lock_s_q;
  logic [3:0]  retry_q, retry_d, retry_inc;
  logic [7:0]  loss_q, loss_d;
  logic        resetb_q, resetb_d;
  logic        sys_reset_q, sys_reset_d;
  logic        ready_q, ready_d;
  logic        fail_q, fail_d;
  logic        lock_lost;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    retry_d   = retry_q;
    loss_d    = loss_q;
    retry_inc = retry_q + 4'd1;
    lock_lost = (state_q == ST_RUN) && !lock_s_q;

    // A lock loss is counted even when RESTART wins the transition.
    if (lock_lost && (loss_q != 8'hFF)) loss_d = loss_q + 8'd1;

    if (bus.RESTART) begin
      state_d = ST_RST;
      cnt_d   = RST_LOAD;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_RST: begin
          if (cnt_q == 16'd1) begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        ST_WAIT: begin
          if (lock_s_q) begin
            state_d = ST_SETTLE;
            cnt_d   = SETTLE_LOAD;
          end else if (cnt_q == 16'd1) begin
            retry_d = retry_inc;
            cnt_d   = RST_LOAD;
            state_d = (retry_inc >= RETRY_MAX) ? ST_FAIL : ST_RST;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        ST_SETTLE: begin
          if (!lock_s_q) begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
          end else if (cnt_q == 16'd1) begin
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        ST_RUN: begin
          if (lock_lost) begin
            state_d = ST_RST;
            cnt_d   = RST_LOAD;
            retry_d = '0;
          end
        end
        ST_FAIL: ;
        default: begin
          state_d = ST_RST;
          cnt_d   = RST_LOAD;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they change in the same cycle as STATE.
  always_comb begin
`ifdef PLL_SEQ_BYPASS_FALLBACK_EN
    resetb_d    = (state_d != ST_RST);
    sys_reset_d = (state_d != ST_RUN) && (state_d != ST_FAIL);
`else
    resetb_d    = (state_d == ST_WAIT) || (state_d == ST_SETTLE) || (state_d == ST_RUN);
    sys_reset_d = (state_d != ST_RUN);
`endif
    ready_d = (state_d == ST_RUN);
    fail_d  = (state_d == ST_FAIL);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_RST;
      cnt_q       <= RST_LOAD;
      sync1_q     <= 1'b0;
      lock_s_q    <= 1'b0;
      retry_q     <= '0;
      loss_q      <= '0;
      resetb_q    <= 1'b0;
      sys_reset_q <= 1'b1;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sync1_q     <= bus.PLL_LOCK;
      lock_s_q    <= sync1_q;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      resetb_q    <= resetb_d;
      sys_reset_q <= sys_reset_d;
      ready_q     <= ready_d;
      fail_q      <= fail_d;
    end
  end

`ifdef PLL_SEQ_BYPASS_FALLBACK_EN
  logic bypass_q;

  always_ff @(posedge CLK) begin
    if (RESET) bypass_q <= 1'b0;
    else       bypass_q <= (state_d == ST_FAIL);
  end

  assign bus.PLL_BYPASS = bypass_q;
`else
  assign bus.PLL_BYPASS = 1'b0;
`endif

  assign bus.PLL_RESETB = resetb_q;
  assign bus.SYS_RESET  = sys_reset_q;
  assign bus.PLL_READY  = ready_q;
  assign bus.PLL_FAIL   = fail_q;
  assign bus.STATE      = state_q;
  assign bus.RETRY_CNT  = retry_q;
  assign bus.LOSS_CNT   = loss_q;

endmodule
